// File: rtl/wb_loader_pkg.sv
`default_nettype none
// wb_loader_pkg: shared FSM states, command opcodes and response codes for the
// byte-stream to Wishbone loader.
package wb_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_TMO  = 8'h54;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  // Single-byte responses sit in the top byte so the serializer always sends MSB first.
  function automatic logic [31:0] rsp_word(input logic [7:0] b);
    return {b, 24'h00_0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_loader_tx.sv
`default_nettype none
// wb_loader_tx: 1-to-4 byte response serializer, MSB first, with a
// valid/ready handshake and a pulse when the final byte is accepted.
module wb_loader_tx (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [1:0]  last_i,
  input  logic [31:0] word_i,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done_o
);

  logic [31:0] shift_q;
  logic [1:0]  left_q;
  logic        valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= 32'h0;
      left_q  <= 2'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= word_i;
      left_q  <= last_i;
      valid_q <= 1'b1;
    end else if (valid_q && tx_ready) begin
      // Shifting in zeros leaves tx_data at 0x00 once the response drains.
      shift_q <= {shift_q[23:0], 8'h00};
      left_q  <= left_q - 2'd1;
      if (left_q == 2'd0) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = shift_q[31:24];
  assign done_o   = valid_q & tx_ready & (left_q == 2'd0);

endmodule
`default_nettype wire

// File: rtl/wb_loader.sv
`default_nettype none
// wb_loader: host byte-stream command decoder driving a single-beat Wishbone
// master with ack timeout and a serialized status/read-data response.
module wb_loader
  import wb_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        cyc_q;
  logic        we_q;
  logic [7:0]  tmo_q;
  logic        rdy_q;

  logic        rx_fire;
  logic        bus_ack;
  logic        bus_tmo;
  logic        bad_op;
  logic        tx_load;
  logic [1:0]  tx_last;
  logic [31:0] tx_word;
  logic        tx_done;

  assign rx_fire = rx_valid & rdy_q;
  assign bus_ack = (state_q == BUS) & wb_ack_i;
  // Ack takes priority over a timeout landing in the same cycle.
  assign bus_tmo = (state_q == BUS) & ~wb_ack_i & (tmo_q == TMO_LAST);
  assign bad_op  = (state_q == IDLE) & rx_fire & (rx_data != OP_WRITE) & (rx_data != OP_READ);

  assign tx_load = bad_op | bus_ack | bus_tmo;
  assign tx_last = (bus_ack && !write_q) ? 2'd3 : 2'd0;
  assign tx_word = bus_ack ? (write_q ? rsp_word(RSP_OK) : wb_data_i)
                 : bus_tmo ? rsp_word(RSP_TMO) : rsp_word(RSP_ERR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      tmo_q   <= 8'd0;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (rx_fire) begin
            cnt_q <= 2'd0;
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              write_q <= (rx_data == OP_WRITE);
              state_q <= ADDR;
            end else begin
              rdy_q   <= 1'b0;
              state_q <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            addr_q <= {addr_q[23:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (write_q) begin
                state_q <= DATA;
              end else begin
                rdy_q   <= 1'b0;
                cyc_q   <= 1'b1;
                we_q    <= 1'b0;
                tmo_q   <= 8'd0;
                state_q <= BUS;
              end
            end
          end
        end
        DATA: begin
          if (rx_fire) begin
            wdata_q <= {wdata_q[23:0], rx_data};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              rdy_q   <= 1'b0;
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              tmo_q   <= 8'd0;
              state_q <= BUS;
            end
          end
        end
        BUS: begin
          if (bus_ack || bus_tmo) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RESP: begin
          if (tx_done) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  wb_loader_tx u_tx (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (tx_load),
    .last_i   (tx_last),
    .word_i   (tx_word),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done_o   (tx_done)
  );

  assign rx_ready    = rdy_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_strobe_o = cyc_q;
  assign wb_we_o     = we_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_loader.sv
`default_nettype none
// tb_wb_loader: directed vectors for wb_loader with a Wishbone responder
// model and a tx byte logger.
module tb_wb_loader;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic        wb_we_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Wishbone responder state
  int          ack_delay = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          bus_count = 0;
  int          stab_err = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic        cap_we = 1'b0;

  // tx logger state
  logic [7:0]  tx_log [0:63];
  int          tx_n = 0;
  int          bp_cycles = 0;
  int          tx_stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  wb_loader #(.TIMEOUT(255)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_we_o     (wb_we_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wb_strobe_o) begin
      cur_len = cur_len + 1;
      if (cur_len == 1) begin
        bus_count = bus_count + 1;
        cap_addr  = wb_addr_o;
        cap_data  = wb_data_o;
        cap_we    = wb_we_o;
      end else if (wb_addr_o !== cap_addr || wb_data_o !== cap_data ||
                   wb_we_o !== cap_we || wb_cyc_o !== 1'b1) begin
        stab_err = stab_err + 1;
      end
      wb_ack_i = (ack_delay != 0) && (cur_len == ack_delay);
    end else begin
      if (cur_len > 0) last_len = cur_len;
      cur_len  = 0;
      wb_ack_i = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data))
      tx_stab_err = tx_stab_err + 1;
    if (tx_valid && bp_cycles > 0) begin
      tx_ready  = 1'b0;
      bp_cycles = bp_cycles - 1;
    end else begin
      tx_ready = 1'b1;
    end
    if (tx_valid && tx_ready && tx_n < 64) begin
      tx_log[tx_n] = tx_data;
      tx_n = tx_n + 1;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
    @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_n < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("tx_count", tx_n, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (op == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  int base;
  int bc;

  initial begin
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b1;
    wb_data_i = 32'h0;
    wb_ack_i  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    chk("rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    chk("rst_wb", {27'h0, wb_cyc_o, wb_strobe_o, wb_we_o, busy, 1'b0}, 32'h0);
    chk("rst_addr", wb_addr_o, 32'h0);
    reset_n = 1'b1;
    #1 chk("rdy_before_edge", {31'h0, rx_ready}, 32'h0);
    @(negedge clock);
    chk("rdy_first_edge", {31'h0, rx_ready}, 32'h1);

    // Write 0x0000000A to 0x00000005, ack in the second strobe cycle
    ack_delay = 2; base = tx_n; bc = bus_count;
    send_byte(8'h57);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    chk("cyc_before_last", {31'h0, wb_cyc_o}, 32'h0);
    send_byte(8'h0A);
    chk("cyc_after_last", {30'h0, wb_cyc_o, wb_strobe_o}, 32'h3);
    chk("busy_bus", {31'h0, busy}, 32'h1);
    wait_tx(base + 1);
    chk("wr_bus_count", bus_count - bc, 1);
    chk("wr_addr", cap_addr, 32'h0000_0005);
    chk("wr_data", cap_data, 32'h0000_000A);
    chk("wr_we", {31'h0, cap_we}, 32'h1);
    chk("wr_stb_len", last_len, 2);
    chk("wr_resp", {24'h0, tx_log[base]}, 32'h4B);
    wait_idle();
    chk("we_after", {31'h0, wb_we_o}, 32'h0);

    // Read 0x00010003 -> DEADBEEF
    ack_delay = 1; wb_data_i = 32'hDEAD_BEEF; base = tx_n;
    send_frame(8'h52, 32'h0001_0003, 32'h0);
    wait_tx(base + 4);
    chk("rd_addr", cap_addr, 32'h0001_0003);
    chk("rd_we", {31'h0, cap_we}, 32'h0);
    chk("rd_resp", {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}, 32'hDEAD_BEEF);
    wait_idle();

    // Timeout: strobe held 255 cycles then 'T'
    ack_delay = 0; base = tx_n;
    send_frame(8'h52, 32'h0000_0010, 32'h0);
    wait_tx(base + 1);
    chk("tmo_stb_len", last_len, 255);
    chk("tmo_resp", {24'h0, tx_log[base]}, 32'h54);
    wait_idle();

    // Bad opcode, then a write still works
    ack_delay = 3; base = tx_n;
    send_byte(8'h41);
    wait_tx(base + 1);
    chk("bad_resp", {24'h0, tx_log[base]}, 32'h45);
    chk("bad_no_bus", {31'h0, wb_cyc_o}, 32'h0);
    wait_idle();
    base = tx_n;
    send_frame(8'h57, 32'h1234_5678, 32'hCAFE_F00D);
    wait_tx(base + 1);
    chk("wr2_addr", cap_addr, 32'h1234_5678);
    chk("wr2_data", cap_data, 32'hCAFE_F00D);
    chk("wr2_stb_len", last_len, 3);
    chk("wr2_resp", {24'h0, tx_log[base]}, 32'h4B);
    wait_idle();

    // Backpressure on the read response
    ack_delay = 1; wb_data_i = 32'h0123_4567; base = tx_n; bp_cycles = 10;
    send_frame(8'h52, 32'hABCD_EF01, 32'h0);
    wait_tx(base + 4);
    wait_idle();
    repeat (3) @(negedge clock);
    chk("bp_count", tx_n - base, 4);
    chk("bp_resp", {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}, 32'h0123_4567);
    chk("bp_stable", tx_stab_err, 0);

    // Reset in the middle of the address phase
    base = tx_n;
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_addr", wb_addr_o, 32'h0);
    chk("mid_rst_ctl", {28'h0, rx_ready, busy, tx_valid, wb_cyc_o}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("mid_rst_no_tx", tx_n, base);
    ack_delay = 2;
    send_frame(8'h57, 32'h0000_0007, 32'h0000_0009);
    wait_tx(base + 1);
    chk("wr3_addr", cap_addr, 32'h0000_0007);
    chk("wr3_data", cap_data, 32'h0000_0009);
    chk("wr3_resp", {24'h0, tx_log[base]}, 32'h4B);
    wait_idle();

    chk("bus_stable", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
